multicycle_control_unit: RTL

- Multi-cycle RISC-V control FSM; next generation of the single-cycle opcode decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives datapath mux selects, register-file write, IR/PC write enables and memory strobes.
- Adds a memory ready handshake, a wait-state timeout, optional I-type ALU and JAL support, and sticky error states.
- Sits between the instruction register (opcode source) and the shared multi-cycle datapath/memory.

---
 rtl/riscv_ctrl_pkg.sv | 64 ++++++
 rtl/mem_timeout_counter.sv | 29 ++
 rtl/multicycle_control_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control unit: opcodes, state
// encodings, datapath select codes and the bundled control-word type.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // FETCH=0 through BUS_ERR=11; the illegal-opcode trap sits just past it.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ALU_WB  = 4'd4,
        ADDR    = 4'd5,
        MEM_RD  = 4'd6,
        LOAD_WB = 4'd7,
        MEM_WR  = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        BUS_ERR = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_OLD_PC = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RFUNC = 2'b10;
    localparam logic [1:0] ALUOP_IFUNC = 2'b11;

    localparam logic [1:0] WB_ALUOUT   = 2'b00;
    localparam logic [1:0] WB_MDR      = 2'b01;
    localparam logic [1:0] WB_PC       = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       instr_retired;
        logic       illegal_instr;
        logic       bus_error;
    } ctrl_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-state counter for memory accesses; flags when the next unready cycle
// would exceed the allowed number of strobe cycles.
module mem_timeout_counter #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturating so that a disabled timeout can wait forever without wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (wait_en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the shared datapath selects, enables and strobes.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ENABLE_ITYPE = 1,
    parameter int ENABLE_JAL   = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] MemtoReg,
    output logic       Reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;
    logic   wait_state;
    logic   expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

    // Any state change restarts the count, which covers entry into every wait state.
    mem_timeout_counter #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d != state_q),
        .wait_en(wait_state && !mem_ready),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (mem_ready)    state_d = DECODE;
                else if (expired) state_d = BUS_ERR;
            end
            DECODE: begin
                if (opcode == OP_R)                             state_d = EXEC_R;
                else if (opcode == OP_I && ENABLE_ITYPE != 0)   state_d = EXEC_I;
                else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = ADDR;
                else if (opcode == OP_BRANCH)                   state_d = BRANCH;
                else if (opcode == OP_JAL && ENABLE_JAL != 0)   state_d = JUMP;
                else                                            state_d = ILLEGAL;
            end
            EXEC_R, EXEC_I: state_d = ALU_WB;
            ADDR:           state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready)    state_d = LOAD_WB;
                else if (expired) state_d = BUS_ERR;
            end
            MEM_WR: begin
                if (mem_ready)    state_d = FETCH;
                else if (expired) state_d = BUS_ERR;
            end
            ALU_WB, LOAD_WB, BRANCH, JUMP: state_d = FETCH;
            ILLEGAL:        state_d = ILLEGAL;
            BUS_ERR:        state_d = BUS_ERR;
            default:        state_d = FETCH;
        endcase
    end

    always_comb begin
        ctrl_raw = '0;
        case (state_q)
            FETCH: begin
                ctrl_raw.mem_read  = 1'b1;
                ctrl_raw.alu_src_a = SRCA_PC;
                ctrl_raw.alu_src_b = SRCB_FOUR;
                ctrl_raw.alu_op    = ALUOP_ADD;
                ctrl_raw.ir_write  = mem_ready;
                ctrl_raw.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl_raw.alu_src_a = SRCA_OLD_PC;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_ADD;
            end
            EXEC_R: begin
                ctrl_raw.alu_src_a = SRCA_RS1;
                ctrl_raw.alu_src_b = SRCB_RS2;
                ctrl_raw.alu_op    = ALUOP_RFUNC;
            end
            EXEC_I: begin
                ctrl_raw.alu_src_a = SRCA_RS1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_IFUNC;
            end
            ALU_WB: begin
                ctrl_raw.reg_write     = 1'b1;
                ctrl_raw.mem_to_reg    = WB_ALUOUT;
                ctrl_raw.instr_retired = 1'b1;
            end
            ADDR: begin
                ctrl_raw.alu_src_a = SRCA_RS1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                ctrl_raw.mem_read = 1'b1;
                ctrl_raw.i_or_d   = 1'b1;
            end
            LOAD_WB: begin
                ctrl_raw.reg_write     = 1'b1;
                ctrl_raw.mem_to_reg    = WB_MDR;
                ctrl_raw.instr_retired = 1'b1;
            end
            MEM_WR: begin
                ctrl_raw.mem_write     = 1'b1;
                ctrl_raw.i_or_d        = 1'b1;
                ctrl_raw.instr_retired = mem_ready;
            end
            BRANCH: begin
                ctrl_raw.alu_src_a     = SRCA_RS1;
                ctrl_raw.alu_src_b     = SRCB_RS2;
                ctrl_raw.alu_op        = ALUOP_SUB;
                ctrl_raw.pc_write_cond = 1'b1;
                ctrl_raw.pc_src        = 1'b1;
                ctrl_raw.instr_retired = 1'b1;
            end
            JUMP: begin
                // PC was already advanced in FETCH, so rd gets the return address.
                ctrl_raw.pc_write      = 1'b1;
                ctrl_raw.pc_src        = 1'b1;
                ctrl_raw.reg_write     = 1'b1;
                ctrl_raw.mem_to_reg    = WB_PC;
                ctrl_raw.instr_retired = 1'b1;
            end
            ILLEGAL: ctrl_raw.illegal_instr = 1'b1;
            BUS_ERR: ctrl_raw.bus_error     = 1'b1;
            default: ctrl_raw = '0;
        endcase
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign ctrl  = reset ? '0 : ctrl_raw;
    assign state = reset ? 4'd0 : state_q;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_src        = ctrl.pc_src;
    assign ir_write      = ctrl.ir_write;
    assign i_or_d        = ctrl.i_or_d;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign ALUOp         = ctrl.alu_op;
    assign MemtoReg      = ctrl.mem_to_reg;
    assign Reg_write     = ctrl.reg_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign instr_retired = ctrl.instr_retired;
    assign illegal_instr = ctrl.illegal_instr;
    assign bus_error     = ctrl.bus_error;

endmodule
